display_scanout: RTL and testbench
==================================

Name: display_scanout

Overview:
- Scan-out and frame-pacing controller for the graphics top level.
- Sweeps raster coordinates that drive the framebuffer read port (x_in/y_in), and takes the 16-bit RGB565 pixel returned one cycle later.
- Emits pipelined RGB888 video with hsync/vsync/de.
- Issues frame_start to the renderer once per frame, and only after the renderer reports frame_done.

Parameters:
- H_ACTIVE, 720, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 62, hsync width
- H_BP, 60, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 9, vertical front porch (lines)
- V_SYNC, 6, vsync width
- V_BP, 30, vertical back porch
- SYNC_ACTIVE, 0, asserted level of hsync/vsync

Ports:
- clk  in  1  pixel clock; same net as the framebuffer read clock
- rst  in  1  synchronous, active-low reset
- x_out  out  $clog2(H_ACTIVE)  framebuffer read column
- y_out  out  $clog2(V_ACTIVE)  framebuffer read row
- pixel_in  in  16  RGB565 from framebuffer; valid 1 clk after x_out/y_out
- frame_start  out  1  one-cycle pulse telling the renderer to begin a frame
- frame_done  in  1  renderer completion (level or pulse)
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  data enable
- rgb_out  out  24  {R8,G8,B8}
- overrun_cnt  out  16  frames where the renderer was still busy at vblank; saturating

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (858). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- h_cnt counts 0..H_TOTAL-1 and wraps to 0.
- v_cnt increments when h_cnt wraps, counts 0..V_TOTAL-1, and wraps to 0.
- Stage 0 (combinational from the counters):
  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - x_out = active ? h_cnt : 0.
  - y_out = active ? v_cnt : 0.
  - hs0 asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC. vs0 uses the same window on v_cnt.
- Stage 1 register: active, hs0, vs0 delayed 1 clk, aligned with pixel_in.
- Stage 2 register (outputs):
  - de, hsync, vsync delayed 2 clks total.
  - rgb_out = de_s1 ? expand(pixel_in) : 24'h0.
  - expand: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
- End-to-end latency: counter state -> rgb/de/syncs = 2 clks. All sync outputs share the same delay.
- Frame FSM states:
  - IDLE: renderer free.
  - RENDER: frame in progress.
- Transitions, evaluated when h_cnt==0 && v_cnt==V_ACTIVE (first vblank line):
  - In IDLE: frame_start=1 for exactly that cycle, go to RENDER.
  - In RENDER: no pulse; overrun_cnt += 1, saturating at 16'hFFFF.
  - In RENDER, frame_done==1 on any cycle -> IDLE on the next cycle.
- Simultaneous events: frame_done high on the evaluation cycle while in RENDER counts as done.
  - Go to IDLE, no overrun increment.
  - No frame_start that frame; the next pulse comes at the following vblank.
- frame_done while IDLE is ignored.
- After reset the FSM is IDLE, so the first frame_start fires at the first vblank (cycle V_ACTIVE*H_TOTAL after reset release).
- Reset (rst==0 at a clk edge), including mid-line or mid-frame:
  - h_cnt=v_cnt=0, FSM=IDLE, pipeline flushed.
  - de=0, rgb_out=0, hsync=vsync=~SYNC_ACTIVE.
  - frame_start=0, overrun_cnt=0.
  - x_out=y_out=0.

Optional Feature:
- Macro: DISPLAY_SCANOUT_TEST_PATTERN_EN.
- When defined: adds input test_pattern (1 bit).
  - When high, stage-2 rgb_out during de is replaced by 8 equal vertical colour bars.
  - Bar index = x_s1 / (H_ACTIVE/8), where x_s1 is x_out delayed 1 clk.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black, at full 8'hFF/8'h00 levels.
  - Timing and FSM are unchanged.
- When undefined: no port and no logic.

Decomposition:
- display_pkg holds:
  - localparams for 480p default timing
  - rgb565_t / rgb888_t packed structs
  - function rgb565_to_888
  - colour-bar constant array
- Sub-module display_timing holds the h/v counters, active flag and raw sync generation (stage 0).
- display_scanout holds the pipeline, FSM and counter.

Test Plan:
- Reset, then run 1 full frame:
  - hsync low for 62 clks per 858.
  - vsync low for 6 lines.
  - de high 720x480 clks per frame.
  - First de edge 2 clks after h_cnt=0,v_cnt=0.
- Drive pixel_in = 16'hF800 when x_out==5 -> rgb_out == 24'hFF0000 exactly 2 clks later with de==1. Drive 16'h07E0 -> 24'h00FF00.
- frame_done never asserted:
  - frame_start pulses once, at cycle 480*858.
  - overrun_cnt == 3 after 4 vblanks.
- frame_done pulsed 1000 clks after each frame_start -> frame_start every 858*525 clks, overrun_cnt stays 0.
- frame_done asserted exactly on the vblank evaluation cycle -> no increment, no pulse that frame, pulse at the next vblank.
- Assert rst at h=300,v=200 for 1 clk:
  - Next cycle x_out=0, de=0, syncs inactive, overrun_cnt=0.
  - frame_start at 480*858 after release.

Source files
------------

// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the display scan-out slice:
//   - default 480p timing (720x480 active, 858x525 total)
//   - frame FSM state type
//   - RGB565 / RGB888 packed pixel structs and the 565->888 expansion
//   - colour-bar table used by the optional test pattern
//     (DISPLAY_SCANOUT_TEST_PATTERN_EN)
// -----------------------------------------------------------------------------
package display_pkg;

  localparam int DEF_H_ACTIVE = 720;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 62;
  localparam int DEF_H_BP     = 60;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 9;
  localparam int DEF_V_SYNC   = 6;
  localparam int DEF_V_BP     = 30;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_RENDER
  } frame_state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red,
  // blue, black.
  localparam logic [0:7][23:0] COLOUR_BARS = {
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  // Replicating the top bits into the new LSBs maps full-scale 565 values
  // onto full-scale 888 values (1F -> FF, 00 -> 00).
  function automatic rgb888_t rgb565_to_888(input rgb565_t p);
    rgb888_t o;
    o.r = {p.r, p.r[4:2]};
    o.g = {p.g, p.g[5:4]};
    o.b = {p.b, p.b[4:2]};
    return o;
  endfunction

endpackage

// File: rtl/display_scanout_if.sv
// -----------------------------------------------------------------------------
// display_scanout_if
// Bundles the scan-out controller's framebuffer read port, video output and
// renderer pacing signals.
//   master (display_scanout): drives x_out, y_out, hsync, vsync, de, rgb_out,
//                             frame_start, overrun_cnt; samples pixel_in,
//                             frame_done
//   slave  (framebuffer/renderer side): the reverse
// Parameters X_W / Y_W are the read address widths ($clog2 of active size).
// -----------------------------------------------------------------------------
interface display_scanout_if
  import display_pkg::*;
#(
  parameter int X_W = $clog2(DEF_H_ACTIVE),
  parameter int Y_W = $clog2(DEF_V_ACTIVE)
);

  logic [X_W-1:0] x_out;
  logic [Y_W-1:0] y_out;
  logic [15:0]    pixel_in;
  logic           frame_start;
  logic           frame_done;
  logic           hsync;
  logic           vsync;
  logic           de;
  logic [23:0]    rgb_out;
  logic [15:0]    overrun_cnt;

  modport master (
    output x_out, y_out, frame_start, hsync, vsync, de, rgb_out, overrun_cnt,
    input  pixel_in, frame_done
  );

  modport slave (
    input  x_out, y_out, frame_start, hsync, vsync, de, rgb_out, overrun_cnt,
    output pixel_in, frame_done
  );

endinterface

// File: rtl/display_timing.sv
// -----------------------------------------------------------------------------
// display_timing
// Stage 0 of the scan-out pipeline: free-running raster counters plus the
// combinational active flag and raw sync windows derived from them.
// Ports:
//   clk, rst         pixel clock, synchronous active-low reset
//   h_cnt, v_cnt     raster position (0..H_TOTAL-1, 0..V_TOTAL-1)
//   active           position lies inside the visible area
//   hs_raw, vs_raw   position lies inside the h/v sync window (true = asserted)
//   tick             first cycle of the first vblank line (h=0, v=V_ACTIVE)
//   tick_next        the cycle immediately before tick
// -----------------------------------------------------------------------------
module display_timing
  import display_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HC_W    = $clog2(H_TOTAL),
  localparam int VC_W    = $clog2(V_TOTAL)
) (
  input  logic            clk,
  input  logic            rst,
  output logic [HC_W-1:0] h_cnt,
  output logic [VC_W-1:0] v_cnt,
  output logic            active,
  output logic            hs_raw,
  output logic            vs_raw,
  output logic            tick,
  output logic            tick_next
);

  localparam logic [HC_W-1:0] H_LAST   = HC_W'(H_TOTAL - 1);
  localparam logic [VC_W-1:0] V_LAST   = VC_W'(V_TOTAL - 1);
  localparam logic [HC_W-1:0] H_ACT_C  = HC_W'(H_ACTIVE);
  localparam logic [VC_W-1:0] V_ACT_C  = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0] V_ACT_M1 = VC_W'(V_ACTIVE - 1);
  localparam logic [HC_W-1:0] HS_START = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0] HS_END   = HC_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VC_W-1:0] VS_START = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0] VS_END   = VC_W'(V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign active    = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign hs_raw    = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_raw    = (v_cnt >= VS_START) && (v_cnt < VS_END);
  assign tick      = (h_cnt == '0) && (v_cnt == V_ACT_C);
  assign tick_next = (h_cnt == H_LAST) && (v_cnt == V_ACT_M1);

endmodule

// File: rtl/display_scanout.sv
// -----------------------------------------------------------------------------
// display_scanout
// Scan-out and frame-pacing controller. Sweeps framebuffer read coordinates,
// converts the returned RGB565 pixels to RGB888 and emits video with
// hsync/vsync/de two clocks after the counter state that produced them.
// Paces the renderer with one frame_start per frame, issued at the first
// vblank line only when the renderer has reported frame_done.
// Ports:
//   clk           pixel clock (also the framebuffer read clock)
//   rst           synchronous, active-low reset
//   test_pattern  (only with DISPLAY_SCANOUT_TEST_PATTERN_EN) replace active
//                 video with 8 vertical colour bars
//   bus           display_scanout_if.master: x_out/y_out/pixel_in,
//                 hsync/vsync/de/rgb_out, frame_start/frame_done, overrun_cnt
// Optional feature macro: DISPLAY_SCANOUT_TEST_PATTERN_EN
// -----------------------------------------------------------------------------
module display_scanout
  import display_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic clk,
  input  logic rst,
`ifdef DISPLAY_SCANOUT_TEST_PATTERN_EN
  input  logic test_pattern,
`endif
  display_scanout_if.master bus
);

  localparam int HC_W = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VC_W = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int X_W  = $clog2(H_ACTIVE);
  localparam int Y_W  = $clog2(V_ACTIVE);

  logic [HC_W-1:0] h_cnt;
  logic [VC_W-1:0] v_cnt;
  logic            active_s0;
  logic            hs_s0;
  logic            vs_s0;
  logic            tick;
  logic            tick_next;
  logic [X_W-1:0]  x_s0;

  logic            active_s1;
  logic            hs_s1;
  logic            vs_s1;
  rgb888_t         pix_rgb;

  frame_state_t    state;

  display_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .active    (active_s0),
    .hs_raw    (hs_s0),
    .vs_raw    (vs_s0),
    .tick      (tick),
    .tick_next (tick_next)
  );

  // Read address is parked at 0 outside the visible area.
  assign x_s0      = active_s0 ? h_cnt[X_W-1:0] : '0;
  assign bus.x_out = x_s0;
  assign bus.y_out = active_s0 ? v_cnt[Y_W-1:0] : '0;

  // Stage 1: control delayed to line up with pixel_in from the framebuffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      active_s1 <= 1'b0;
      hs_s1     <= 1'b0;
      vs_s1     <= 1'b0;
    end else begin
      active_s1 <= active_s0;
      hs_s1     <= hs_s0;
      vs_s1     <= vs_s0;
    end
  end

`ifdef DISPLAY_SCANOUT_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [X_W-1:0] x_s1;
  logic [X_W-1:0] bar_full;
  logic [2:0]     bar_sel;

  always_ff @(posedge clk) begin
    if (!rst) begin
      x_s1 <= '0;
    end else begin
      x_s1 <= x_s0;
    end
  end

  // Columns past the last full bar (H_ACTIVE not a multiple of 8) stay black.
  assign bar_full = x_s1 / X_W'(BAR_W);
  assign bar_sel  = (bar_full > X_W'(7)) ? 3'd7 : bar_full[2:0];
`endif

  always_comb begin
    pix_rgb = rgb565_to_888(rgb565_t'(bus.pixel_in));
`ifdef DISPLAY_SCANOUT_TEST_PATTERN_EN
    if (test_pattern) begin
      pix_rgb = rgb888_t'(COLOUR_BARS[bar_sel]);
    end
`endif
  end

  // Stage 2: registered video outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.de      <= 1'b0;
      bus.hsync   <= ~SYNC_ACTIVE;
      bus.vsync   <= ~SYNC_ACTIVE;
      bus.rgb_out <= '0;
    end else begin
      bus.de      <= active_s1;
      bus.hsync   <= hs_s1 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      bus.vsync   <= vs_s1 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      bus.rgb_out <= active_s1 ? pix_rgb : '0;
    end
  end

  // Frame pacing. frame_start is registered one cycle early (on tick_next)
  // so it is high during the tick cycle itself. The state seen on the tick
  // cycle will be IDLE if it already is, or if the renderer reports done on
  // the cycle before, hence the frame_done term.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= ST_IDLE;
      bus.frame_start <= 1'b0;
      bus.overrun_cnt <= '0;
    end else begin
      bus.frame_start <= tick_next && ((state == ST_IDLE) || bus.frame_done);
      case (state)
        ST_IDLE: begin
          if (tick) begin
            state <= ST_RENDER;
          end
        end
        ST_RENDER: begin
          // Done on the tick cycle wins over the overrun.
          if (bus.frame_done) begin
            state <= ST_IDLE;
          end else if (tick && (bus.overrun_cnt != 16'hFFFF)) begin
            bus.overrun_cnt <= bus.overrun_cnt + 16'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_scanout.sv
// -----------------------------------------------------------------------------
// tb_display_scanout
// Bench for display_scanout using a reduced raster (24x13 total) so several
// frames fit in a short run. A bench-side raster/frame model predicts every
// cycle; video expectations are queued when the pixel is addressed and
// compared when they emerge two clocks later.
// -----------------------------------------------------------------------------
module tb_display_scanout;

  localparam int TH_ACTIVE  = 16;
  localparam int TH_FP      = 2;
  localparam int TH_SYNC    = 3;
  localparam int TH_BP      = 3;
  localparam int TH_TOTAL   = 24;
  localparam int TV_ACTIVE  = 8;
  localparam int TV_FP      = 1;
  localparam int TV_SYNC    = 2;
  localparam int TV_BP      = 2;
  localparam int TV_TOTAL   = 13;
  localparam int FRAME      = TH_TOTAL * TV_TOTAL;
  localparam int FIRST_FS   = TV_ACTIVE * TH_TOTAL;
  localparam int DONE_DELAY = 100;
  localparam int XW         = $clog2(TH_ACTIVE);
  localparam int YW         = $clog2(TV_ACTIVE);

  typedef struct {
    logic [26:0] vid;
    int          kind;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tp  = 1'b0;

  display_scanout_if #(.X_W(XW), .Y_W(YW)) bus ();

  display_scanout #(
    .H_ACTIVE    (TH_ACTIVE),
    .H_FP        (TH_FP),
    .H_SYNC      (TH_SYNC),
    .H_BP        (TH_BP),
    .V_ACTIVE    (TV_ACTIVE),
    .V_FP        (TV_FP),
    .V_SYNC      (TV_SYNC),
    .V_BP        (TV_BP),
    .SYNC_ACTIVE (1'b0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef DISPLAY_SCANOUT_TEST_PATTERN_EN
    .test_pattern (tp),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  int   mh, mv, m_over, t, done_cd;
  bit   m_render;
  int   stat_cyc, hs_low, vs_low, de_hi;
  int   fs_count, fs_first, fs_last;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  function automatic logic [15:0] pixOf(input int x, input int y);
    if (x == 5) return 16'hF800;
    if (x == 6) return 16'h07E0;
    return 16'((x * 1237) ^ (y * 4099) ^ 16'h5A5A);
  endfunction

  function automatic logic [23:0] expand565(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  task automatic applyReset();
    exp_t e;
    rst = 1'b0;
    bus.frame_done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    e.vid  = {1'b0, 1'b1, 1'b1, 24'h0};
    e.kind = 3;
    sb.push_back(e);
    sb.push_back(e);
    mh = 0; mv = 0; m_render = 0; m_over = 0; t = 0; done_cd = 0;
    stat_cyc = 0; hs_low = 0; vs_low = 0; de_hi = 0;
    fs_count = 0; fs_first = -1; fs_last = -1;
  endtask

  // One pixel clock: drive frame_done, check outputs, advance model and DUT.
  task automatic applyStimulus(input int mode);
    bit          eval, m_act, exp_fs, fd, hs_m, vs_m;
    exp_t        e, g;
    logic [15:0] pix;
    logic [26:0] got;
    eval = (mh == 0) && (mv == TV_ACTIVE);
    case (mode)
      1: begin
        fd = (done_cd == 1);
        if (done_cd > 0) done_cd--;
      end
      2: fd = eval && m_render;
      default: fd = 1'b0;
    endcase
    bus.frame_done = fd;

    exp_fs = eval && !m_render;
    m_act  = (mh < TH_ACTIVE) && (mv < TV_ACTIVE);
    checkOutput("frame_start", 32'(bus.frame_start), 32'(exp_fs));
    checkOutput("overrun_cnt", 32'(bus.overrun_cnt), m_over);
    checkOutput("x_out", 32'(bus.x_out), m_act ? mh : 0);
    checkOutput("y_out", 32'(bus.y_out), m_act ? mv : 0);
    if (bus.frame_start) begin
      fs_count++;
      if (fs_count == 1) fs_first = t;
      else if (mode == 1) checkOutput("fs_period", t - fs_last, FRAME);
      fs_last = t;
    end
    if (mode == 1 && exp_fs) done_cd = DONE_DELAY;

    hs_m   = !((mh >= TH_ACTIVE + TH_FP) && (mh < TH_ACTIVE + TH_FP + TH_SYNC));
    vs_m   = !((mv >= TV_ACTIVE + TV_FP) && (mv < TV_ACTIVE + TV_FP + TV_SYNC));
    e.vid  = {m_act, hs_m, vs_m, m_act ? expand565(pixOf(mh, mv)) : 24'h0};
    e.kind = !m_act ? 0 : (mh == 5) ? 1 : (mh == 6) ? 2 : 0;
    sb.push_back(e);
    g   = sb.pop_front();
    got = {bus.de, bus.hsync, bus.vsync, bus.rgb_out};
    case (g.kind)
      1: checkOutput("rgb_red", 32'(got), 32'(g.vid));
      2: checkOutput("rgb_green", 32'(got), 32'(g.vid));
      3: checkOutput("video_flush", 32'(got), 32'(g.vid));
      default: checkOutput("video", 32'(got), 32'(g.vid));
    endcase

    if (stat_cyc < FRAME) begin
      stat_cyc++;
      if (!bus.hsync) hs_low++;
      if (!bus.vsync) vs_low++;
      if (bus.de) de_hi++;
    end

    pix = pixOf(int'(bus.x_out), int'(bus.y_out));

    if (eval) begin
      if (!m_render) m_render = 1'b1;
      else if (fd) m_render = 1'b0;
      else if (m_over < 65535) m_over++;
    end else if (m_render && fd) begin
      m_render = 1'b0;
    end
    mh++;
    if (mh == TH_TOTAL) begin
      mh = 0;
      mv++;
      if (mv == TV_TOTAL) mv = 0;
    end

    @(posedge clk);
    #1 bus.pixel_in = pix;
    t++;
    @(negedge clk);
  endtask

  task automatic runCycles(input int n, input int mode);
    for (int i = 0; i < n; i++) applyStimulus(mode);
  endtask

  task automatic runUntil(input int h, input int v, input int mode);
    int guard;
    guard = 0;
    while (!(mh == h && mv == v) && guard < 2 * FRAME) begin
      applyStimulus(mode);
      guard++;
    end
    if (guard >= 2 * FRAME) checkOutput("runUntil_timeout", 0, 1);
  endtask

  initial begin
    bus.pixel_in   = 16'h0;
    bus.frame_done = 1'b0;
    @(negedge clk);
    applyReset();

    // Renderer never finishes: one pulse, then overruns at each vblank.
    runCycles(FIRST_FS + 3 * FRAME + 2, 0);
    checkOutput("hsync_low_frame", hs_low, TH_SYNC * TV_TOTAL);
    checkOutput("vsync_low_frame", vs_low, TV_SYNC * TH_TOTAL);
    checkOutput("de_high_frame", de_hi, TH_ACTIVE * TV_ACTIVE);
    checkOutput("fs_count_nodone", fs_count, 1);
    checkOutput("fs_first_nodone", fs_first, FIRST_FS);
    checkOutput("overrun_4vb", 32'(bus.overrun_cnt), 3);

    // Mid-frame reset for one clock.
    runUntil(10, 5, 0);
    applyReset();
    checkOutput("rst_x_out", 32'(bus.x_out), 0);
    checkOutput("rst_y_out", 32'(bus.y_out), 0);
    checkOutput("rst_de", 32'(bus.de), 0);
    checkOutput("rst_hsync", 32'(bus.hsync), 1);
    checkOutput("rst_vsync", 32'(bus.vsync), 1);
    checkOutput("rst_overrun", 32'(bus.overrun_cnt), 0);
    checkOutput("rst_frame_start", 32'(bus.frame_start), 0);
    runCycles(FIRST_FS + 2, 0);
    checkOutput("fs_first_after_rst", fs_first, FIRST_FS);
    checkOutput("fs_count_after_rst", fs_count, 1);

    // Renderer finishes well before every vblank.
    applyReset();
    runCycles(FIRST_FS + 4 * FRAME + 2, 1);
    checkOutput("fs_count_done", fs_count, 5);
    checkOutput("overrun_done", 32'(bus.overrun_cnt), 0);

    // Renderer finishes exactly on the evaluation cycle.
    applyReset();
    runCycles(FIRST_FS + 4 * FRAME + 2, 2);
    checkOutput("fs_count_simul", fs_count, 3);
    checkOutput("fs_last_simul", fs_last, FIRST_FS + 4 * FRAME);
    checkOutput("overrun_simul", 32'(bus.overrun_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
